// File: rtl/multicycle_control_if.sv
// Handshake/control bundle between the multicycle controller and the MIPS datapath.
// The controller side is "master"; the datapath/memory side is "slave".
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  // datapath -> controller
  logic [5:0]       opcode;
  logic             mem_ready;

  // controller -> datapath
  logic             PCWrite;
  logic             PCWriteCond;
  logic [1:0]       PCSource;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;

  // status / debug
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             illegal;
  logic [3:0]       state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           instr_done, instr_count, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           instr_done, instr_count, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  FETCH  (0) | read instr at PC, PC+4 -> PC and IR load when memory ready
//  DECODE (1) | read rs/rt, precompute branch target (PC + imm<<2)
//  MEMADR (2) | ALUOut = rs + sign-ext imm for lw/sw
//  MEMRD  (3) | load data read at ALUOut, waits for mem_ready
//  MEMWB  (4) | MDR -> rt, lw retires
//  MEMWR  (5) | store to ALUOut, retires when mem_ready
//  RDEXEC (6) | R-type ALU operation, funct-decoded
//  RWB    (7) | ALUOut -> rd, R-type retires
//  BRANCH (8) | beq compare, PC <= ALUOut if zero, retires
//  JUMP   (9) | PC <= jump target, retires
//  IEXEC (10) | andi: rs & sign-ext imm
//  IWB   (11) | ALUOut -> rt, andi retires
//  TRAP  (15) | illegal opcode, all strobes off, left only through reset
//
// Moore outputs are registered from the next state so they change with the state
// register. Only the FETCH IR/PC loads and the MEMWR retire pulse additionally follow
// mem_ready combinationally, since the memory completes within the same cycle.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RDEXEC = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_AND  = 2'b11;

  // Registered Moore controls. fetch/memwr_done mark the strobes that are
  // qualified by mem_ready at the output.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       done;
    logic       fetch;
    logic       memwr_done;
  } ctrl_t;

  state_t      state_q;
  state_t      state_nxt;
  ctrl_t       ctrl_q;
  logic        illegal_q;
  logic [CNT_W-1:0] count_q;
  logic        instr_done;

  // Control word for each state; anything not named is 0.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_source = PCSRC_ALU;
        c.fetch     = 1'b1;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
      end
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      MEMWR: begin
        c.mem_write  = 1'b1;
        c.iord       = 1'b1;
        c.memwr_done = 1'b1;
      end
      RDEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNC;
      end
      RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_OUT;
        c.done          = 1'b1;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JMP;
        c.done      = 1'b1;
      end
      IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_AND;
      end
      IWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection: instruction dispatch in DECODE, memory stalls in FETCH/MEMRD/MEMWR.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      FETCH:  if (bus.mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      state_nxt = RDEXEC;
          OP_LW, OP_SW:  state_nxt = MEMADR;
          OP_BEQ:        state_nxt = BRANCH;
          OP_J:          state_nxt = JUMP;
          OP_ANDI:       state_nxt = IEXEC;
          default:       state_nxt = TRAP;
        endcase
      end
      MEMADR: state_nxt = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) state_nxt = MEMWB;
      MEMWB:  state_nxt = FETCH;
      MEMWR:  if (bus.mem_ready) state_nxt = FETCH;
      RDEXEC: state_nxt = RWB;
      RWB:    state_nxt = FETCH;
      BRANCH: state_nxt = FETCH;
      JUMP:   state_nxt = FETCH;
      IEXEC:  state_nxt = IWB;
      IWB:    state_nxt = FETCH;
      TRAP:   state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  assign instr_done = ctrl_q.done | (ctrl_q.memwr_done & bus.mem_ready);

  // State register, registered controls, sticky trap flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ctrl_q    <= decode_ctrl(FETCH);
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode_ctrl(state_nxt);
      if (state_nxt == TRAP) illegal_q <= 1'b1;
      if (instr_done) count_q <= count_q + CNT_W'(1);
    end
  end

  // Output mapping; IR/PC loads in FETCH only happen on the cycle memory returns data.
  assign bus.PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready);
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.IRWrite     = ctrl_q.fetch & bus.mem_ready;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.instr_done  = instr_done;
  assign bus.instr_count = count_q;
  assign bus.illegal     = illegal_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: stimulus pushes the expected per-cycle control word
// and per-instruction cycle count; a monitor pops and compares every checked cycle.
module tb_multicycle_control;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]       st;
    logic             pcw;
    logic             pcwc;
    logic [1:0]       pcs;
    logic             iord;
    logic             mrd;
    logic             mwr;
    logic             irw;
    logic             m2r;
    logic             rdst;
    logic             rw;
    logic             asa;
    logic [1:0]       asb;
    logic [1:0]       aop;
    logic             done;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   ret_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001100};

  // Expected controls for a cycle spent in a given phase, straight from the control table.
  function automatic exp_t expect_for(input int ph, input logic mr, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e = '0;
    e.st  = ph[3:0];
    e.cnt = cnt;
    case (ph)
      0:  begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      1:  e.asb = 2'b11;
      2:  begin e.asa = 1; e.asb = 2'b10; end
      3:  begin e.mrd = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
      5:  begin e.mwr = 1; e.iord = 1; e.done = mr; end
      6:  begin e.asa = 1; e.aop = 2'b10; end
      7:  begin e.rw = 1; e.rdst = 1; e.done = 1; end
      8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1; end
      9:  begin e.pcw = 1; e.pcs = 2'b10; e.done = 1; end
      10: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; end
      11: begin e.rw = 1; e.done = 1; end
      15: e.ill = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs after the edge and record what the DUT must show.
  task automatic step(input int ph, input logic mr, input logic [5:0] op);
    exp_t e;
    @(posedge clk);
    #1;
    bus.mem_ready = mr;
    bus.opcode    = op;
    e = expect_for(ph, mr, exp_cnt);
    exp_q.push_back(e);
    if (e.done) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Runs one instruction; legal ones push their total cycle count for the retire check.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    int ph[$];
    int n;
    int stalls;
    n = 0;
    case (op)
      6'b000000: ph = '{0, 1, 6, 7};
      6'b100011: ph = '{0, 1, 2, 3, 4};
      6'b101011: ph = '{0, 1, 2, 5};
      6'b000100: ph = '{0, 1, 8};
      6'b000010: ph = '{0, 1, 9};
      6'b001100: ph = '{0, 1, 10, 11};
      default:   ph = '{0, 1};
    endcase
    for (int k = 0; k < ph.size(); k++) begin
      if (ph[k] == 0 || ph[k] == 3 || ph[k] == 5) begin
        stalls = (ph[k] == 0) ? fst : mst;
        repeat (stalls) begin
          step(ph[k], 1'b0, (ph[k] == 0) ? 6'($urandom) : op);
          n++;
        end
        step(ph[k], 1'b1, (ph[k] == 0) ? 6'($urandom) : op);
        n++;
      end else begin
        step(ph[k], 1'($urandom), op);
        n++;
      end
    end
    if (ph.size() > 2) ret_q.push_back(n);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_state", int'(bus.state), 0);
    chk("reset_illegal", int'(bus.illegal), 0);
    chk("reset_count", int'(bus.instr_count), 0);
    chk("reset_memwrite", int'(bus.MemWrite), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  // Monitor: compare each recorded cycle, and check retire spacing on every done pulse.
  int cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    exp_t obs;
    int req;
    if (!rst_n) begin
      cyc = 0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      obs = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead,
             bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
             bus.ALUSrcB, bus.ALUOp, bus.instr_done, bus.illegal, bus.instr_count};
      cyc++;
      n_assert++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL cycle_controls phase %0d: got %h expected %h (state %0d)",
                 e.st, obs, e, bus.state);
      end
      if (bus.instr_done === 1'b1) begin
        n_assert++;
        if (ret_q.size() == 0) begin
          n_fail++;
          $display("FAIL retire_cycles: got done after %0d cycles expected no retire", cyc);
        end else begin
          req = ret_q.pop_front();
          if (cyc != req) begin
            n_fail++;
            $display("FAIL retire_cycles: got %0d expected %0d", cyc, req);
          end
        end
        cyc = 0;
      end
    end else if (bus.instr_done !== 1'b0) begin
      n_assert++;
      n_fail++;
      $display("FAIL idle_done: got %b expected 0", bus.instr_done);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'(bus.state), 0);
    chk("reset_count", int'(bus.instr_count), 0);
    chk("reset_illegal", int'(bus.illegal), 0);
    chk("reset_memread", int'(bus.MemRead), 1);
    chk("reset_irwrite", int'(bus.IRWrite), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // directed: R, lw with 2 read stalls, sw, beq, j, andi
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 2);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001100, 0, 0);
    run_instr(6'b101011, 2, 3);

    // random legal mix with random stalls
    for (int i = 0; i < 30; i++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // traps: the all-ones opcode, then a random illegal one
    for (int t = 0; t < 2; t++) begin
      if (t == 0) op = 6'b111111;
      else begin
        op = 6'($urandom);
        while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001100})
          op = 6'($urandom);
      end
      run_instr(op, $urandom_range(0, 1), 0);
      repeat (10) step(15, 1'($urandom), 6'($urandom));
      apply_reset();
    end

    // counter wrap: 16 R-types from zero
    for (int i = 0; i < 16; i++) run_instr(6'b000000, 0, 0);
    step(0, 1'b1, 6'($urandom));
    chk("count_wrap", int'(bus.instr_count), 0);

    // reset while a store is stalled in MEMWR
    step(1, 1'b0, 6'b101011);
    step(2, 1'b1, 6'b101011);
    step(5, 1'b0, 6'b101011);
    @(negedge clk);
    #2;
    chk("memwr_before_reset", int'(bus.MemWrite), 1);
    chk("memwr_state", int'(bus.state), 5);
    apply_reset();
    run_instr(6'b000000, 1, 0);

    @(negedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("retire_drained", ret_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
